// File: rtl/rf_pkg.sv
// rf_pkg: shared widths and types for the register-file write arbiter.
package rf_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int SW         = 36;
    localparam int VW         = 32;
    localparam int VLANES     = 4;

    typedef logic [VLANES-1:0][VW-1:0] vreg_t;

    typedef struct packed {
        logic                  is_vec;
        logic [REG_ADDR_W-1:0] addr;
        logic [SW-1:0]         sdata;
        vreg_t                 vdata;
        logic [VLANES-1:0]     mask;
    } wr_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant for one write port, with a per-candidate
// wait counter that forces a long-waiting candidate to win.
module rr_arbiter #(
    parameter int NREQ     = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] cand_i,
    output logic [NREQ-1:0] grant_o
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [PW-1:0]            ptr_q, ptr_d;
    logic [NREQ-1:0][CW-1:0]  cnt_q, cnt_d;
    logic                     found;
    logic [PW-1:0]            j;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        ptr_d   = ptr_q;
        j       = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && cand_i[i] && cnt_q[i] == CW'(MAX_WAIT)) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            j = PW'(idx);
            if (!found && cand_i[j]) begin
                grant_o[j] = 1'b1;
                found      = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (grant_o[i]) begin
                if (i + 1 == NREQ) ptr_d = '0;
                else               ptr_d = PW'(i + 1);
            end
            if (cand_i[i] && !grant_o[i]) begin
                if (cnt_q[i] == CW'(MAX_WAIT)) cnt_d[i] = cnt_q[i];
                else                           cnt_d[i] = cnt_q[i] + CW'(1);
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert ($onehot0(grant_o));
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the scalar and vector register-file write ports
// among NREQ writeback requesters; the winning write is registered.
module rf_write_arbiter #(
    parameter int NREQ     = 2,
    parameter int SW       = rf_pkg::SW,
    parameter int VW       = rf_pkg::VW,
    parameter int VLANES   = rf_pkg::VLANES,
    parameter int MAX_WAIT = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NREQ-1:0]                            req_valid,
    output logic [NREQ-1:0]                            req_ready,
    input  logic [NREQ-1:0]                            req_is_vec,
    input  logic [NREQ-1:0][rf_pkg::REG_ADDR_W-1:0]    req_addr,
    input  logic [NREQ-1:0][SW-1:0]                    req_sdata,
    input  logic [NREQ-1:0][VLANES-1:0][VW-1:0]        req_vdata,
    input  logic [NREQ-1:0][VLANES-1:0]                req_mask,
    output logic                                       s_wr_en,
    output logic [rf_pkg::REG_ADDR_W-1:0]              r_write_addr,
    output logic [SW-1:0]                              write_data,
    output logic [rf_pkg::REG_ADDR_W-1:0]              v_write_addr,
    output logic [VLANES-1:0][VW-1:0]                  write_vector,
    output logic [VLANES-1:0]                          mask
);
    localparam int AW = rf_pkg::REG_ADDR_W;

    logic [NREQ-1:0] s_cand, v_cand, s_gnt, v_gnt;

    assign s_cand = req_valid & ~req_is_vec;
    assign v_cand = req_valid & req_is_vec;

    rr_arbiter #(.NREQ(NREQ), .MAX_WAIT(MAX_WAIT)) u_sarb (
        .clk(clk), .rst(rst), .cand_i(s_cand), .grant_o(s_gnt)
    );

    rr_arbiter #(.NREQ(NREQ), .MAX_WAIT(MAX_WAIT)) u_varb (
        .clk(clk), .rst(rst), .cand_i(v_cand), .grant_o(v_gnt)
    );

    assign req_ready = (s_gnt | v_gnt) & {NREQ{~rst}};

    logic                        s_wr_en_q;
    logic [AW-1:0]               s_addr_q, s_addr_d;
    logic [SW-1:0]               s_data_q, s_data_d;
    logic [AW-1:0]               v_addr_q, v_addr_d;
    logic [VLANES-1:0][VW-1:0]   v_data_q, v_data_d;
    logic [VLANES-1:0]           v_mask_q, v_mask_d;

    always_comb begin
        s_addr_d = '0;
        s_data_d = '0;
        v_addr_d = '0;
        v_data_d = '0;
        v_mask_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (s_gnt[i]) begin
                s_addr_d = req_addr[i];
                s_data_d = req_sdata[i];
            end
            if (v_gnt[i]) begin
                v_addr_d = req_addr[i];
                v_data_d = req_vdata[i];
                v_mask_d = req_mask[i];
            end
        end
    end

    // Scalar address/data hold between writes; a zero mask means no vector write.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_wr_en_q <= 1'b0;
            s_addr_q  <= '0;
            s_data_q  <= '0;
            v_addr_q  <= '0;
            v_data_q  <= '0;
            v_mask_q  <= '0;
        end else begin
            s_wr_en_q <= |s_gnt;
            if (|s_gnt) begin
                s_addr_q <= s_addr_d;
                s_data_q <= s_data_d;
            end
            v_mask_q <= v_mask_d;
            if (|v_gnt) begin
                v_addr_q <= v_addr_d;
                v_data_q <= v_data_d;
            end
        end
    end

    assign s_wr_en      = s_wr_en_q;
    assign r_write_addr = s_addr_q;
    assign write_data   = s_data_q;
    assign v_write_addr = v_addr_q;
    assign write_vector = v_data_q;
    assign mask         = v_mask_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed table, hand sequences and a randomized
// run against a behavioural model of the write arbiter.
module tb_rf_write_arbiter;
    localparam int MAXW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]             req_valid, req_ready, req_is_vec;
    logic [1:0][4:0]        req_addr;
    logic [1:0][35:0]       req_sdata;
    logic [1:0][3:0][31:0]  req_vdata;
    logic [1:0][3:0]        req_mask;
    logic                   s_wr_en;
    logic [4:0]             r_write_addr, v_write_addr;
    logic [35:0]            write_data;
    logic [3:0][31:0]       write_vector;
    logic [3:0]             mask;

    rf_write_arbiter #(.NREQ(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_vec(req_is_vec), .req_addr(req_addr),
        .req_sdata(req_sdata), .req_vdata(req_vdata),
        .req_mask(req_mask), .s_wr_en(s_wr_en),
        .r_write_addr(r_write_addr), .write_data(write_data),
        .v_write_addr(v_write_addr), .write_vector(write_vector),
        .mask(mask)
    );

    logic [0:0]             n1_valid, n1_ready, n1_vec;
    logic [0:0][4:0]        n1_addr;
    logic [0:0][35:0]       n1_sdata;
    logic [0:0][3:0][31:0]  n1_vdata;
    logic [0:0][3:0]        n1_mask;
    logic                   n1_sen;
    logic [4:0]             n1_saddr, n1_vaddr;
    logic [35:0]            n1_sdat;
    logic [3:0][31:0]       n1_vvec;
    logic [3:0]             n1_vmask;

    rf_write_arbiter #(.NREQ(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(n1_valid), .req_ready(n1_ready),
        .req_is_vec(n1_vec), .req_addr(n1_addr),
        .req_sdata(n1_sdata), .req_vdata(n1_vdata),
        .req_mask(n1_mask), .s_wr_en(n1_sen),
        .r_write_addr(n1_saddr), .write_data(n1_sdat),
        .v_write_addr(n1_vaddr), .write_vector(n1_vvec),
        .mask(n1_vmask)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [159:0] act,
                       input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [35:0] mk_s(input int i, input logic [4:0] a);
        return {4'(i + 1), 27'h0, a};
    endfunction

    function automatic logic [127:0] mk_v(input int i, input logic [4:0] a);
        return {4{3'(i + 1), 24'hA5A5A5, a}};
    endfunction

    task automatic drive(input logic [1:0] v, input logic [1:0] vec,
                         input logic [4:0] a0, input logic [4:0] a1,
                         input logic [3:0] m0, input logic [3:0] m1);
        req_valid    = v;
        req_is_vec   = vec;
        req_addr[0]  = a0;
        req_addr[1]  = a1;
        req_sdata[0] = mk_s(0, a0);
        req_sdata[1] = mk_s(1, a1);
        req_vdata[0] = mk_v(0, a0);
        req_vdata[1] = mk_v(1, a1);
        req_mask[0]  = m0;
        req_mask[1]  = m1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(2'b00, 2'b00, 5'd0, 5'd0, 4'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0] v;
        logic [1:0] vec;
        logic [4:0] a0;
        logic [4:0] a1;
        logic [3:0] m;
        logic [1:0] rdy;
        logic       sen;
        logic [4:0] saddr;
        int         sw;
        logic [3:0] vmask;
        logic [4:0] vaddr;
        int         vw;
    } row_t;

    row_t tbl[9];

    // behavioural model state for the randomized run
    int sptr, vptr;
    int wc[2];
    bit pv[2], pvec[2];
    logic [4:0]   pa[2];
    logic [35:0]  psd[2];
    logic [127:0] pvd[2];
    logic [3:0]   pm[2];
    bit           es;
    logic [4:0]   esa, eva;
    logic [35:0]  esd;
    logic [127:0] evd;
    logic [3:0]   em;

    function automatic int pick(input logic [1:0] cand, input int ptr);
        for (int i = 0; i < 2; i++)
            if (cand[i] && wc[i] >= MAXW) return i;
        for (int k = 0; k < 2; k++)
            if (cand[(ptr + k) % 2]) return (ptr + k) % 2;
        return -1;
    endfunction

    initial begin
        int x0, x1;
        n1_valid = 1'b0; n1_vec = 1'b0; n1_addr[0] = 5'd2;
        n1_sdata[0] = 36'h0000000AB; n1_vdata[0] = '0; n1_mask[0] = 4'h0;

        tbl[0] = '{2'b00, 2'b00, 5'd0, 5'd0, 4'h0, 2'b00, 1'b0, 5'd0, 0, 4'h0, 5'd0, 0};
        tbl[1] = '{2'b01, 2'b00, 5'd3, 5'd0, 4'h0, 2'b01, 1'b1, 5'd3, 0, 4'h0, 5'd0, 0};
        tbl[2] = '{2'b11, 2'b00, 5'd9, 5'd9, 4'h0, 2'b10, 1'b1, 5'd9, 1, 4'h0, 5'd0, 0};
        tbl[3] = '{2'b11, 2'b00, 5'd9, 5'd9, 4'h0, 2'b01, 1'b1, 5'd9, 0, 4'h0, 5'd0, 0};
        tbl[4] = '{2'b11, 2'b10, 5'd5, 5'd7, 4'hA, 2'b11, 1'b1, 5'd5, 0, 4'hA, 5'd7, 1};
        tbl[5] = '{2'b11, 2'b11, 5'd4, 5'd6, 4'h3, 2'b01, 1'b0, 5'd0, 0, 4'h3, 5'd4, 0};
        tbl[6] = '{2'b11, 2'b11, 5'd4, 5'd6, 4'h3, 2'b10, 1'b0, 5'd0, 0, 4'h3, 5'd6, 1};
        tbl[7] = '{2'b10, 2'b10, 5'd0, 5'd8, 4'h0, 2'b10, 1'b0, 5'd0, 0, 4'h0, 5'd0, 0};
        tbl[8] = '{2'b00, 2'b00, 5'd0, 5'd0, 4'h0, 2'b00, 1'b0, 5'd0, 0, 4'h0, 5'd0, 0};

        // reset hold with requests pending, then idle
        rst = 1'b1;
        drive(2'b11, 2'b01, 5'd1, 5'd2, 4'hF, 4'hF);
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            chk("rst_ready", req_ready, 2'b00);
            chk("rst_sen", s_wr_en, 1'b0);
            chk("rst_mask", mask, 4'h0);
            chk("rst_waddr", r_write_addr, 5'd0);
            @(posedge clk); #1;
        end
        rst = 1'b0;

        for (int r = 0; r < 9; r++) begin
            drive(tbl[r].v, tbl[r].vec, tbl[r].a0, tbl[r].a1, tbl[r].m, tbl[r].m);
            #1;
            chk($sformatf("tbl%0d_ready", r), req_ready, tbl[r].rdy);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_sen", r), s_wr_en, tbl[r].sen);
            chk($sformatf("tbl%0d_mask", r), mask, tbl[r].vmask);
            if (tbl[r].sen) begin
                chk($sformatf("tbl%0d_saddr", r), r_write_addr, tbl[r].saddr);
                chk($sformatf("tbl%0d_sdata", r), write_data, mk_s(tbl[r].sw, tbl[r].saddr));
            end
            if (tbl[r].vmask != 4'h0) begin
                chk($sformatf("tbl%0d_vaddr", r), v_write_addr, tbl[r].vaddr);
                chk($sformatf("tbl%0d_vdata", r), write_vector, mk_v(tbl[r].vw, tbl[r].vaddr));
            end
        end

        // two scalar requesters held from reset alternate 0,1,0,1
        do_reset();
        drive(2'b11, 2'b00, 5'd10, 5'd11, 4'h0, 4'h0);
        x0 = 0; x1 = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("alt%0d_ready", c), req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
            if (req_ready[0]) x0++;
            if (req_ready[1]) x1++;
            @(posedge clk); #1;
            chk($sformatf("alt%0d_sen", c), s_wr_en, 1'b1);
            chk($sformatf("alt%0d_addr", c), r_write_addr, (c % 2 == 0) ? 5'd10 : 5'd11);
        end
        chk("alt_xfer0", x0, 2);
        chk("alt_xfer1", x1, 2);

        // lone scalar write with a specific payload
        drive(2'b01, 2'b00, 5'd3, 5'd0, 4'h0, 4'h0);
        req_sdata[0] = 36'h123456789;
        #1;
        chk("solo_ready", req_ready, 2'b01);
        @(posedge clk); #1;
        chk("solo_sen", s_wr_en, 1'b1);
        chk("solo_addr", r_write_addr, 5'd3);
        chk("solo_data", write_data, 36'h123456789);

        // starvation override with the scalar pointer pinned to requester 0
        do_reset();
        force dut.u_sarb.ptr_q = 1'b0;
        drive(2'b11, 2'b00, 5'd12, 5'd13, 4'h0, 4'h0);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("starve%0d_ready", c), req_ready, (c < 4) ? 2'b01 : 2'b10);
            @(posedge clk); #1;
        end
        release dut.u_sarb.ptr_q;

        // reset right after a vector grant
        do_reset();
        drive(2'b10, 2'b10, 5'd0, 5'd7, 4'h0, 4'hF);
        #1;
        chk("vrst_ready", req_ready, 2'b10);
        @(posedge clk); #1;
        chk("vrst_mask1", mask, 4'hF);
        rst = 1'b1;
        drive(2'b11, 2'b11, 5'd1, 5'd2, 4'h5, 4'h6);
        #1;
        chk("vrst_ready_in_rst", req_ready, 2'b00);
        @(posedge clk); #1;
        chk("vrst_mask0", mask, 4'h0);
        chk("vrst_sen0", s_wr_en, 1'b0);
        rst = 1'b0;
        #1;
        chk("vrst_vptr0", req_ready, 2'b01);
        @(posedge clk); #1;
        drive(2'b11, 2'b00, 5'd1, 5'd2, 4'h0, 4'h0);
        #1;
        chk("vrst_sptr0", req_ready, 2'b01);
        @(posedge clk); #1;

        // single-requester instance always grants
        drive(2'b00, 2'b00, 5'd0, 5'd0, 4'h0, 4'h0);
        n1_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("n1_%0d_ready", c), n1_ready, 1'b1);
            @(posedge clk); #1;
            chk($sformatf("n1_%0d_sen", c), n1_sen, 1'b1);
        end
        n1_valid = 1'b0;

        // randomized run against the behavioural model
        do_reset();
        sptr = 0; vptr = 0; wc = '{0, 0}; pv = '{0, 0}; pvec = '{0, 0};
        es = 0; esa = '0; esd = '0; em = '0; eva = '0; evd = '0;
        for (int n = 0; n < 400; n++) begin
            bit dorst;
            int sw, vw;
            logic [1:0] sc, vc, er;
            chk("rnd_sen", s_wr_en, es);
            chk("rnd_saddr", r_write_addr, esa);
            chk("rnd_sdata", write_data, esd);
            chk("rnd_mask", mask, em);
            if (em != 4'h0) begin
                chk("rnd_vaddr", v_write_addr, eva);
                chk("rnd_vdata", write_vector, evd);
            end
            dorst = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!pv[i] && $urandom_range(0, 3) != 0) begin
                    pv[i]   = 1'b1;
                    pvec[i] = 1'($urandom_range(0, 1));
                    pa[i]   = 5'($urandom);
                    psd[i]  = 36'({$urandom, $urandom});
                    pvd[i]  = {$urandom, $urandom, $urandom, $urandom};
                    pm[i]   = 4'($urandom);
                end
                req_valid[i]  = pv[i];
                req_is_vec[i] = pvec[i];
                req_addr[i]   = pa[i];
                req_sdata[i]  = psd[i];
                req_vdata[i]  = pvd[i];
                req_mask[i]   = pm[i];
            end
            rst = dorst;
            #1;
            sc = {pv[1] & ~pvec[1], pv[0] & ~pvec[0]};
            vc = {pv[1] & pvec[1], pv[0] & pvec[0]};
            sw = pick(sc, sptr);
            vw = pick(vc, vptr);
            er = 2'b00;
            if (!dorst) begin
                if (sw >= 0) er[sw] = 1'b1;
                if (vw >= 0) er[vw] = 1'b1;
            end
            chk("rnd_ready", req_ready, er);
            if (dorst) begin
                sptr = 0; vptr = 0; wc = '{0, 0};
                es = 0; esa = '0; esd = '0; em = '0; eva = '0; evd = '0;
            end else begin
                es = (sw >= 0);
                if (sw >= 0) begin
                    esa = pa[sw]; esd = psd[sw]; sptr = (sw + 1) % 2;
                end
                em = '0;
                if (vw >= 0) begin
                    em = pm[vw]; eva = pa[vw]; evd = pvd[vw]; vptr = (vw + 1) % 2;
                end
                for (int i = 0; i < 2; i++) begin
                    if (pv[i] && !er[i]) wc[i] = (wc[i] < MAXW) ? wc[i] + 1 : MAXW;
                    else                 wc[i] = 0;
                    if (er[i]) pv[i] = 1'b0;
                end
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        chk("rnd_final_sen", s_wr_en, es);
        chk("rnd_final_mask", mask, em);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
